// File: rtl/gshare_ras_predictor.sv
// gshare_ras_predictor
//   Fetch-stage next-PC predictor for the 5-stage RV32I core. It combines a
//   tagged direct-mapped BTB, a gshare PHT of 2-bit counters, a global history
//   register and a circular return address stack. Prediction is combinational
//   for IF. The EX stage supplies resolutions, which update all state on the
//   next rising edge.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   if_pc, if_is_ret    fetch PC and predecoded "ret" flag
//   pred_pc, pred_taken predicted next PC; high when it differs from if_pc+4
//   ex_valid            one resolving control instruction this cycle
//   ex_pc, ex_pred_pc   its PC and the prediction carried with it
//   ex_is_branch/call/ret, ex_taken, ex_target   resolved behaviour
//   ex_mispredict       resolved next PC differs from the carried prediction
//   redirect_pc         resolved next PC
//   n_resolved, n_mispredict   saturating event counters
module gshare_ras_predictor #(
  parameter int ADDR_W    = 32,
  parameter int BTB_IDX_W = 5,
  parameter int PHT_IDX_W = 5,
  parameter int GHR_W     = 5,
  parameter int RAS_DEPTH = 8,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_is_ret,
  output logic [ADDR_W-1:0] pred_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_pred_pc,
  input  logic              ex_is_branch,
  input  logic              ex_is_call,
  input  logic              ex_is_ret,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              ex_mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  n_resolved,
  output logic [CNT_W-1:0]  n_mispredict
);

  localparam int BTB_N  = 1 << BTB_IDX_W;
  localparam int PHT_N  = 1 << PHT_IDX_W;
  localparam int TAG_W  = ADDR_W - BTB_IDX_W - 2;
  localparam int PTR_W  = $clog2(RAS_DEPTH);
  localparam int RCNT_W = PTR_W + 1;

  // 2-bit saturating direction counter
  function automatic logic [1:0] ctr2_next(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Event counter that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic              r_btb_vld [BTB_N];
  logic [TAG_W-1:0]  r_btb_tag [BTB_N];
  logic [ADDR_W-1:0] r_btb_tgt [BTB_N];
  logic              r_btb_unc [BTB_N];
  logic [1:0]        r_pht     [PHT_N];
  logic [GHR_W-1:0]  r_ghr;
  logic [ADDR_W-1:0] r_ras     [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ras_ptr;   // next free slot; top is r_ras_ptr-1
  logic [RCNT_W-1:0] r_ras_cnt;
  logic [CNT_W-1:0]  r_n_res;
  logic [CNT_W-1:0]  r_n_mis;

  // Lookup
  logic [BTB_IDX_W-1:0] w_if_bidx;
  logic [TAG_W-1:0]     w_if_tag;
  logic [PHT_IDX_W-1:0] w_ghr_ext;
  logic [PHT_IDX_W-1:0] w_if_pidx;
  logic                 w_if_hit;
  logic [ADDR_W-1:0]    w_if_pc4;
  logic [PTR_W-1:0]     w_ras_top_ptr;
  logic                 w_ras_empty;
  logic                 w_ras_full;
  logic [ADDR_W-1:0]    w_pred;

  assign w_if_bidx     = if_pc[BTB_IDX_W+1:2];
  assign w_if_tag      = if_pc[ADDR_W-1:BTB_IDX_W+2];
  assign w_ghr_ext     = PHT_IDX_W'(r_ghr);
  assign w_if_pidx     = if_pc[PHT_IDX_W+1:2] ^ w_ghr_ext;
  assign w_if_hit      = r_btb_vld[w_if_bidx] && (r_btb_tag[w_if_bidx] == w_if_tag);
  assign w_if_pc4      = if_pc + ADDR_W'(4);
  assign w_ras_top_ptr = r_ras_ptr - PTR_W'(1);
  assign w_ras_empty   = (r_ras_cnt == '0);
  assign w_ras_full    = (r_ras_cnt == RCNT_W'(RAS_DEPTH));

  always_comb begin
    w_pred = w_if_pc4;
    if (if_is_ret && !w_ras_empty)
      w_pred = r_ras[w_ras_top_ptr];
    else if (w_if_hit && r_btb_unc[w_if_bidx])
      w_pred = r_btb_tgt[w_if_bidx];
    else if (w_if_hit && r_pht[w_if_pidx][1])
      w_pred = r_btb_tgt[w_if_bidx];
  end

  assign pred_pc    = w_pred;
  assign pred_taken = (w_pred != w_if_pc4);

  // Resolution
  logic [ADDR_W-1:0]    w_ex_pc4;
  logic [ADDR_W-1:0]    w_actual;
  logic [BTB_IDX_W-1:0] w_ex_bidx;
  logic [PHT_IDX_W-1:0] w_ex_pidx;
  logic [GHR_W:0]       w_ghr_shift;
  logic                 w_push;
  logic                 w_replace;
  logic                 w_pop;

  assign w_ex_pc4      = ex_pc + ADDR_W'(4);
  assign w_actual      = ex_taken ? ex_target : w_ex_pc4;
  assign ex_mispredict = ex_valid && (w_actual != ex_pred_pc);
  assign redirect_pc   = w_actual;
  assign w_ex_bidx     = ex_pc[BTB_IDX_W+1:2];
  assign w_ex_pidx     = ex_pc[PHT_IDX_W+1:2] ^ w_ghr_ext;
  // Upper GHR_W bits are the history after shifting ex_taken in at the top
  assign w_ghr_shift   = {ex_taken, r_ghr};

  // call+ret on an empty stack degenerates to a plain push
  assign w_push    = ex_valid && ex_is_call && (!ex_is_ret || w_ras_empty);
  assign w_replace = ex_valid && ex_is_call && ex_is_ret && !w_ras_empty;
  assign w_pop     = ex_valid && ex_is_ret && !ex_is_call && !w_ras_empty;

  // State update edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_N; i++) r_btb_vld[i] <= 1'b0;
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= 2'b01;
      r_ghr     <= '0;
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
      r_n_res   <= '0;
      r_n_mis   <= '0;
    end else begin
      if (ex_valid) begin
        r_n_res <= sat_inc(r_n_res);
        if (ex_mispredict) r_n_mis <= sat_inc(r_n_mis);
        if (ex_is_branch) begin
          r_pht[w_ex_pidx] <= ctr2_next(r_pht[w_ex_pidx], ex_taken);
          r_ghr            <= w_ghr_shift[GHR_W:1];
        end
        if (ex_taken) r_btb_vld[w_ex_bidx] <= 1'b1;
      end
      if (w_push) begin
        r_ras_ptr <= r_ras_ptr + PTR_W'(1);
        // When full the write lands on the oldest slot and the depth stays put
        if (!w_ras_full) r_ras_cnt <= r_ras_cnt + RCNT_W'(1);
      end else if (w_pop) begin
        r_ras_ptr <= w_ras_top_ptr;
        r_ras_cnt <= r_ras_cnt - RCNT_W'(1);
      end
    end
  end

  // Payload storage; qualified by the valid bits and RAS count above
  always_ff @(posedge clk) begin
    if (ex_valid && ex_taken) begin
      r_btb_tag[w_ex_bidx] <= ex_pc[ADDR_W-1:BTB_IDX_W+2];
      r_btb_tgt[w_ex_bidx] <= ex_target;
      r_btb_unc[w_ex_bidx] <= !ex_is_branch;
    end
    if (w_push)
      r_ras[r_ras_ptr] <= w_ex_pc4;
    else if (w_replace)
      r_ras[w_ras_top_ptr] <= w_ex_pc4;
  end

  assign n_resolved   = r_n_res;
  assign n_mispredict = r_n_mis;

endmodule
